// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle logic/arithmetic, bit-serial shifts.
// Operands are captured on a valid/ready accept; result is registered.
module multicycle_alu #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [3:0]            ALU_Operation_i,
  input  logic [DATA_WIDTH-1:0] A_i,
  input  logic [DATA_WIDTH-1:0] B_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  zero_o,
  output logic                  done_o
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_SLL = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b0110;
  localparam logic [3:0] OP_BEQ = 4'b0111;
  localparam logic [3:0] OP_JAL = 4'b1000;
  localparam logic [3:0] OP_LUI = 4'b1111;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [DATA_WIDTH-1:0]  alu_res;
  logic [DATA_WIDTH-1:0]  work;
  logic [DATA_WIDTH-1:0]  shifted;
  logic [SHAMT_WIDTH-1:0] count;
  logic [SHAMT_WIDTH-1:0] shamt;
  logic                   shift_right;
  logic                   is_shift;
  logic                   accept;
  logic                   start_shift;

  assign shamt       = B_i[SHAMT_WIDTH-1:0];
  assign is_shift    = (ALU_Operation_i == OP_SLL)
                     | (ALU_Operation_i == OP_SRL);
  assign accept      = valid_i & ready_o;
  assign start_shift = is_shift & (shamt != '0);
  assign shifted     = shift_right ? (work >> 1)
                                   : (work << 1);

  // Shift with zero amount falls through here as a plain copy of A.
  always_comb begin
    alu_res = '0;
    case (ALU_Operation_i)
      OP_ADD:  alu_res = A_i + B_i;
      OP_SUB:  alu_res = A_i - B_i;
      OP_XOR:  alu_res = A_i ^ B_i;
      OP_OR:   alu_res = A_i | B_i;
      OP_AND:  alu_res = A_i & B_i;
      OP_SLL:  alu_res = A_i;
      OP_SRL:  alu_res = A_i;
      OP_BEQ:  alu_res = A_i - B_i;
      OP_JAL:  alu_res = A_i + DATA_WIDTH'(4);
      OP_LUI:  alu_res = B_i;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = IDLE;
    unique case (state)
      IDLE, DONE: begin
        if (accept)
          state_nx = start_shift ? SHIFT : DONE;
        else
          state_nx = IDLE;
      end
      SHIFT: begin
        state_nx = (count == SHAMT_WIDTH'(1))
                 ? DONE : SHIFT;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    ready_o = (state != SHIFT);
    done_o  = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result_o    <= '0;
      zero_o      <= 1'b0;
      work        <= '0;
      count       <= '0;
      shift_right <= 1'b0;
    end else if (state == SHIFT) begin
      work  <= shifted;
      count <= count - SHAMT_WIDTH'(1);
      if (count == SHAMT_WIDTH'(1)) begin
        result_o <= shifted;
        zero_o   <= (shifted == '0);
      end
    end else if (accept) begin
      if (start_shift) begin
        work        <= A_i;
        count       <= shamt;
        shift_right <= (ALU_Operation_i == OP_SRL);
      end else begin
        result_o <= alu_res;
        zero_o   <= (alu_res == '0);
      end
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed testbench for multicycle_alu.
// Each task drives one scenario and checks outputs inline.
module tb_multicycle_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_i;
  logic        ready_o;
  logic [3:0]  ALU_Operation_i;
  logic [31:0] A_i;
  logic [31:0] B_i;
  logic [31:0] result_o;
  logic        zero_o;
  logic        done_o;

  int total = 0;
  int bad   = 0;

  multicycle_alu dut (
    .clk             (clk),
    .reset           (reset),
    .valid_i         (valid_i),
    .ready_o         (ready_o),
    .ALU_Operation_i (ALU_Operation_i),
    .A_i             (A_i),
    .B_i             (B_i),
    .result_o        (result_o),
    .zero_o          (zero_o),
    .done_o          (done_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one op, waits for the accept edge, then scrambles inputs.
  // Returns 1 ns after the accept edge (cycle N+1).
  task automatic issue(input logic [3:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b);
    int n;
    ALU_Operation_i = op;
    A_i     = a;
    B_i     = b;
    valid_i = 1'b1;
    n = 0;
    while (!ready_o && n < 100) begin
      step();
      n++;
    end
    total++;
    if (!ready_o) begin
      bad++;
      $display("FAIL issue_ready timeout op=%b", op);
    end
    step();
    valid_i = 1'b0;
    ALU_Operation_i = 4'($urandom);
    A_i = $urandom;
    B_i = $urandom;
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    valid_i = 1'b1;
    ALU_Operation_i = 4'b0000;
    A_i = 32'd1;
    B_i = 32'd1;
    step();
    step();
    total++;
    if (ready_o !== 1'b1 || done_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctl ready=%b done=%b want 1 0",
               ready_o, done_o);
    end
    total++;
    if (result_o !== 32'd0 || zero_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_data res=%h zero=%b want 0 0",
               result_o, zero_o);
    end
    reset   = 1'b0;
    valid_i = 1'b0;
    step();
    total++;
    if (done_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_valid_ignored done=%b want 0", done_o);
    end
  endtask

  task automatic test_add();
    issue(4'b0000, 32'd5, 32'd7);
    total++;
    if (done_o !== 1'b1 || result_o !== 32'd12 || zero_o !== 1'b0) begin
      bad++;
      $display("FAIL add done=%b res=%h zero=%b want 1 0000000c 0",
               done_o, result_o, zero_o);
    end
    step();
    total++;
    if (done_o !== 1'b0 || result_o !== 32'd12) begin
      bad++;
      $display("FAIL add_hold done=%b res=%h want 0 0000000c",
               done_o, result_o);
    end
  endtask

  task automatic test_ops();
    logic [3:0]  op  [8];
    logic [31:0] a   [8];
    logic [31:0] b   [8];
    logic [31:0] exp [8];
    logic        ez  [8];
    op[0]=4'b0111; a[0]=32'h33;         b[0]=32'h33;
    exp[0]=32'h0;          ez[0]=1'b1;
    op[1]=4'b0111; a[1]=32'd4;          b[1]=32'd3;
    exp[1]=32'd1;          ez[1]=1'b0;
    op[2]=4'b0001; a[2]=32'd3;          b[2]=32'd5;
    exp[2]=32'hFFFF_FFFE;  ez[2]=1'b0;
    op[3]=4'b0011; a[3]=32'hF000_000F;  b[3]=32'h0F00_00F0;
    exp[3]=32'hFF00_00FF;  ez[3]=1'b0;
    op[4]=4'b0100; a[4]=32'hF0F0_F0F0;  b[4]=32'h0F0F_0F0F;
    exp[4]=32'h0;          ez[4]=1'b1;
    op[5]=4'b1000; a[5]=32'h100;        b[5]=32'h55;
    exp[5]=32'h104;        ez[5]=1'b0;
    op[6]=4'b1111; a[6]=32'h99;         b[6]=32'h1234_5000;
    exp[6]=32'h1234_5000;  ez[6]=1'b0;
    op[7]=4'b1010; a[7]=32'd5;          b[7]=32'd9;
    exp[7]=32'h0;          ez[7]=1'b1;
    for (int i = 0; i < 8; i++) begin
      issue(op[i], a[i], b[i]);
      total++;
      if (done_o !== 1'b1 || result_o !== exp[i] || zero_o !== ez[i]) begin
        bad++;
        $display("FAIL op%b done=%b res=%h zero=%b want 1 %h %b",
                 op[i], done_o, result_o, zero_o, exp[i], ez[i]);
      end
      step();
    end
  endtask

  task automatic test_shift();
    int busy;
    issue(4'b0101, 32'd1, 32'd31);
    busy = 0;
    for (int i = 0; i < 31; i++) begin
      if (ready_o === 1'b0 && done_o === 1'b0) busy++;
      step();
    end
    total++;
    if (busy != 31) begin
      bad++;
      $display("FAIL sll31_busy cycles=%0d want 31", busy);
    end
    total++;
    if (done_o !== 1'b1 || result_o !== 32'h8000_0000 || ready_o !== 1'b1) begin
      bad++;
      $display("FAIL sll31 done=%b res=%h ready=%b want 1 80000000 1",
               done_o, result_o, ready_o);
    end
    step();
    issue(4'b0110, 32'h8000_0000, 32'd0);
    total++;
    if (done_o !== 1'b1 || result_o !== 32'h8000_0000) begin
      bad++;
      $display("FAIL srl0 done=%b res=%h want 1 80000000",
               done_o, result_o);
    end
    step();
    // Upper bits of B beyond the shift amount must be ignored.
    issue(4'b0110, 32'h0000_00F0, 32'h0000_0024);
    for (int i = 0; i < 4; i++) step();
    total++;
    if (done_o !== 1'b1 || result_o !== 32'h0F || zero_o !== 1'b0) begin
      bad++;
      $display("FAIL srl4 done=%b res=%h zero=%b want 1 0000000f 0",
               done_o, result_o, zero_o);
    end
    step();
    issue(4'b0101, 32'h8000_0000, 32'd1);
    step();
    total++;
    if (done_o !== 1'b1 || result_o !== 32'h0 || zero_o !== 1'b1) begin
      bad++;
      $display("FAIL sll1 done=%b res=%h zero=%b want 1 0 1",
               done_o, result_o, zero_o);
    end
    step();
  endtask

  task automatic test_back_to_back();
    ALU_Operation_i = 4'b0000;
    A_i = 32'd1;
    B_i = 32'd1;
    valid_i = 1'b1;
    step();
    ALU_Operation_i = 4'b0010;
    A_i = 32'hF0;
    B_i = 32'hFF;
    total++;
    if (done_o !== 1'b1 || result_o !== 32'd2 || ready_o !== 1'b1) begin
      bad++;
      $display("FAIL b2b_first done=%b res=%h ready=%b want 1 2 1",
               done_o, result_o, ready_o);
    end
    step();
    valid_i = 1'b0;
    total++;
    if (done_o !== 1'b1 || result_o !== 32'h0F) begin
      bad++;
      $display("FAIL b2b_second done=%b res=%h want 1 0000000f",
               done_o, result_o);
    end
    step();
    total++;
    if (done_o !== 1'b0) begin
      bad++;
      $display("FAIL b2b_end done=%b want 0", done_o);
    end
  endtask

  task automatic test_reset_mid_shift();
    int spurious;
    issue(4'b0110, 32'hFFFF_FFFF, 32'd20);
    for (int i = 0; i < 4; i++) step();
    total++;
    if (ready_o !== 1'b0) begin
      bad++;
      $display("FAIL midshift_busy ready=%b want 0", ready_o);
    end
    reset   = 1'b1;
    valid_i = 1'b1;
    ALU_Operation_i = 4'b0000;
    step();
    reset   = 1'b0;
    valid_i = 1'b0;
    total++;
    if (ready_o !== 1'b1 || result_o !== 32'd0 ||
        done_o !== 1'b0 || zero_o !== 1'b0) begin
      bad++;
      $display("FAIL midshift_reset ready=%b res=%h done=%b zero=%b want 1 0 0 0",
               ready_o, result_o, done_o, zero_o);
    end
    spurious = 0;
    for (int i = 0; i < 24; i++) begin
      if (done_o !== 1'b0) spurious++;
      step();
    end
    total++;
    if (spurious != 0) begin
      bad++;
      $display("FAIL midshift_discard done_pulses=%0d want 0", spurious);
    end
    issue(4'b0000, 32'd3, 32'd4);
    total++;
    if (done_o !== 1'b1 || result_o !== 32'd7) begin
      bad++;
      $display("FAIL post_reset_add done=%b res=%h want 1 7",
               done_o, result_o);
    end
    step();
  endtask

  initial begin
    reset = 1'b1;
    valid_i = 1'b0;
    ALU_Operation_i = 4'b0;
    A_i = 32'd0;
    B_i = 32'd0;
    #1;
    test_reset();
    test_add();
    test_ops();
    test_shift();
    test_back_to_back();
    test_reset_mid_shift();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
